// File: rtl/spectrum_streamer_pkg.sv
// Shared types for the spectrum ping-pong streamer: bin formats,
// packed bin record and the read-side FSM encoding.
package data_type;

  localparam int LAMBDA_W = 14;
  localparam int ANG_W    = 11;
  localparam int N_BINS   = 256;

  typedef logic signed [LAMBDA_W-1:0] lambda_t;
  typedef logic signed [ANG_W-1:0]    ang_t;

  typedef struct packed {
    lambda_t lambda;
    ang_t    angle;
  } spec_bin_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_GAP
  } rd_state_e;

endpackage

// File: rtl/spectrum_streamer_ram.sv
// pp_bank_ram: two-bank frame store, one write port, one synchronous
// read port. Ports: i_clk, i_rst_n, i_wr_en/addr/data, i_rd_en/addr, o_rd_data.
module pp_bank_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 25,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Array is never cleared; only the read register is, so the
  // streamer's data outputs come up as zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spectrum_streamer.sv
// Ping-pong frame buffer: accepts bins via wr_valid/wr_ready, replays each
// full frame as a gap-free burst (out_*), counts frames in frames_out.
// Option SPEC_STREAMER_REVERSE_EN: emit each frame from idx N-1 down to 0.
module spectrum_streamer
  import data_type::*;
#(
  parameter int N = N_BINS,
  parameter int FRAME_GAP = 0,
  localparam int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [LAMBDA_W-1:0] wr_lambda,
  input  logic [ANG_W-1:0]    wr_angle,
  output logic                out_valid,
  output logic                out_first,
  output logic [LAMBDA_W-1:0] out_lambda,
  output logic [ANG_W-1:0]    out_angle,
  output logic [AW-1:0]       out_idx,
  output logic [15:0]         frames_out
);

`ifdef SPEC_STREAMER_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_cnt;
  logic [3:0]    r_gap_cnt;
  rd_state_e     r_state;

  logic          r_out_valid;
  logic          r_out_first;
  logic          r_out_last;
  logic [AW-1:0] r_out_idx;
  logic [15:0]   r_frames;

  rd_state_e     w_state_nxt;
  logic [AW-1:0] w_rd_cnt_nxt;
  logic [3:0]    w_gap_nxt;
  logic          w_rd_en;
  logic          w_rd_done;
  logic [AW-1:0] w_rd_idx;
  logic          w_wr_fire;
  logic          w_wr_done;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;
  spec_bin_t     w_wr_bin;
  spec_bin_t     w_rd_bin;

  assign wr_ready  = !r_full[r_wr_bank];
  assign w_wr_fire = wr_valid && wr_ready;
  assign w_wr_done = w_wr_fire && (r_wr_ptr == LAST);
  assign w_wr_bin  = '{lambda: wr_lambda, angle: wr_angle};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_fire) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_wr_done) begin
        r_wr_bank <= !r_wr_bank;
      end
    end
  end

  // r_rd_cnt is the frame position being issued; it is 0 whenever
  // the FSM sits in IDLE or GAP.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_rd_en      = 1'b0;
    w_rd_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_rd_en      = 1'b1;
          w_rd_cnt_nxt = AW'(1);
          w_state_nxt  = S_STREAM;
        end
      end
      S_STREAM: begin
        w_rd_en      = 1'b1;
        w_rd_cnt_nxt = r_rd_cnt + AW'(1);
        if (r_rd_cnt == LAST) begin
          w_rd_done    = 1'b1;
          w_rd_cnt_nxt = '0;
          if (FRAME_GAP > 0) begin
            w_gap_nxt   = '0;
            w_state_nxt = S_GAP;
          end else if (r_full[!r_rd_bank]) begin
            w_state_nxt = S_STREAM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 4'(FRAME_GAP - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rd_cnt  <= '0;
      r_gap_cnt <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_gap_cnt <= w_gap_nxt;
      if (w_rd_done) begin
        r_rd_bank <= !r_rd_bank;
      end
    end
  end

  // Reverse order: N is a power of two, so N-1-cnt is ~cnt.
  assign w_rd_idx = REV ? ~r_rd_cnt : r_rd_cnt;

  assign w_set = w_wr_done ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_clr = w_rd_done ? (2'b01 << r_rd_bank) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
    end
  end

  // Writer only fills a non-full bank and reader only drains a full one.
  a_set_clr: assert property (
    @(posedge clk) disable iff (!rst) !(|(w_set & w_clr))
  );

  pp_bank_ram #(
    .DEPTH(2 * N),
    .WIDTH($bits(spec_bin_t))
  ) u_ram (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_wr_en  (w_wr_fire),
    .i_wr_addr({r_wr_bank, r_wr_ptr}),
    .i_wr_data(w_wr_bin),
    .i_rd_en  (w_rd_en),
    .i_rd_addr({r_rd_bank, w_rd_idx}),
    .o_rd_data(w_rd_bin)
  );

  // Index/valid/strobe delayed one cycle to line up with RAM data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
    end else begin
      r_out_valid <= w_rd_en;
      r_out_first <= w_rd_en && (r_rd_cnt == '0);
      r_out_last  <= w_rd_en && (r_rd_cnt == LAST);
      if (w_rd_en) begin
        r_out_idx <= w_rd_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frames <= '0;
    end else if (r_out_valid && r_out_last) begin
      r_frames <= r_frames + 16'd1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_first  = r_out_first;
  assign out_idx    = r_out_idx;
  assign out_lambda = w_rd_bin.lambda;
  assign out_angle  = w_rd_bin.angle;
  assign frames_out = r_frames;

endmodule

// File: tb/tb_spectrum_streamer.sv
// Bench for spectrum_streamer: random writes, frame-level reference
// model feeding an expected-bin queue, decoupled output monitor.
module tb_spectrum_streamer;

  localparam int N = 256;
`ifdef SPEC_STREAMER_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [13:0] wr_lambda = '0;
  logic [10:0] wr_angle = '0;
  logic        out_valid, out_first;
  logic [13:0] out_lambda;
  logic [10:0] out_angle;
  logic [7:0]  out_idx;
  logic [15:0] frames_out;

  logic        g_wr_valid = 1'b0;
  logic        g_wr_ready;
  logic [13:0] g_wr_lambda = '0;
  logic        g_out_valid, g_out_first;
  logic [13:0] g_out_lambda;
  logic [10:0] g_out_angle;
  logic [7:0]  g_out_idx;
  logic [15:0] g_frames_out;

  spectrum_streamer #(.N(N), .FRAME_GAP(0)) u_dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_lambda(wr_lambda), .wr_angle(wr_angle),
    .out_valid(out_valid), .out_first(out_first),
    .out_lambda(out_lambda), .out_angle(out_angle),
    .out_idx(out_idx), .frames_out(frames_out)
  );

  spectrum_streamer #(.N(N), .FRAME_GAP(3)) u_gap (
    .clk(clk), .rst(rst),
    .wr_valid(g_wr_valid), .wr_ready(g_wr_ready),
    .wr_lambda(g_wr_lambda), .wr_angle(11'd0),
    .out_valid(g_out_valid), .out_first(g_out_first),
    .out_lambda(g_out_lambda), .out_angle(g_out_angle),
    .out_idx(g_out_idx), .frames_out(g_frames_out)
  );

  typedef struct {
    logic [7:0]  idx;
    logic [13:0] lam;
    logic [10:0] ang;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [13:0] p_lam[$];
  logic [10:0] p_ang[$];

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int t_done = 0;
  bit lat_armed = 0;
  bit mid = 0;
  int run = 0;
  int last_run = 0;
  logic [15:0] exp_frames = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: a frame becomes output only once all N bins are in;
  // it is then replayed whole, in index order (or reversed).
  function automatic void push_bin(input logic [13:0] l, input logic [10:0] a);
    exp_t e;
    int k;
    p_lam.push_back(l);
    p_ang.push_back(a);
    if (p_lam.size() == N) begin
      for (int i = 0; i < N; i++) begin
        k = REV ? N - 1 - i : i;
        e.idx   = 8'(k);
        e.lam   = p_lam[k];
        e.ang   = p_ang[k];
        e.first = (i == 0);
        e.last  = (i == N - 1);
        q.push_back(e);
      end
      p_lam.delete();
      p_ang.delete();
      t_done = cyc;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("frames_out", 32'(frames_out), 32'(exp_frames));
      if (out_valid) begin
        run++;
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_bin got idx %0d want none", out_idx);
        end else begin
          e = q.pop_front();
          chk("bin", {out_idx, out_lambda, out_angle, out_first},
              {e.idx, e.lam, e.ang, e.first});
          if (lat_armed && e.first) begin
            chk("first_latency", 32'(cyc), 32'(t_done + 2));
            lat_armed = 0;
          end
          mid = !e.last;
          if (e.last) exp_frames++;
        end
      end else begin
        if (run > 0) last_run = run;
        run = 0;
        chk("no_hole_in_frame", 32'(mid), 32'(0));
        mid = 0;
      end
    end
  end

  int gpos = 0;
  int g_idle = 0;
  bit g_seen_last = 0;
  int g_gap_checks = 0;

  always @(negedge clk) begin
    int gi;
    if (rst && g_out_valid) begin
      gi = REV ? N - 1 - gpos : gpos;
      chk("gap_dut_idx", 32'(g_out_idx), 32'(gi));
      chk("gap_dut_lambda", 32'(g_out_lambda), 32'(gi));
      chk("gap_dut_first", 32'(g_out_first), 32'(gpos == 0));
      if (g_out_first && g_seen_last) begin
        chk("gap_idle_cycles", 32'(g_idle), 32'(3));
        g_gap_checks++;
      end
      g_idle = 0;
      g_seen_last = (gpos == N - 1);
      gpos = (gpos + 1) % N;
    end else if (rst && g_seen_last) begin
      g_idle++;
    end
  end

  task automatic wr_bins(input int n, input int duty, input bit ramp);
    int done = 0;
    int guard = 0;
    bit v;
    while (done < n && guard < 20 * n + 1000) begin
      @(negedge clk);
      guard++;
      v = ($urandom_range(99) < duty);
      wr_lambda = ramp ? 14'(done) : 14'($urandom);
      wr_angle  = ramp ? 11'(-done) : 11'($urandom);
      wr_valid  = v;
      if (v && wr_ready) begin
        push_bin(wr_lambda, wr_angle);
        done++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("write_progress", 32'(done), 32'(n));
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 32'(q.size()), 32'(0));
    repeat (4) @(negedge clk);
  endtask

  task automatic flush_model();
    q.delete();
    p_lam.delete();
    p_ang.delete();
    mid = 0;
    run = 0;
    exp_frames = '0;
    lat_armed = 0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_first", 32'(out_first), 32'(0));
    chk("rst_out_lambda", 32'(out_lambda), 32'(0));
    chk("rst_out_angle", 32'(out_angle), 32'(0));
    chk("rst_out_idx", 32'(out_idx), 32'(0));
    chk("rst_frames_out", 32'(frames_out), 32'(0));
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'(1));

    // ramp frame, first-bin latency
    lat_armed = 1;
    wr_bins(N, 100, 1);
    drain();
    chk("ramp_frames", 32'(frames_out), 32'(1));
    chk("ramp_latency_seen", 32'(lat_armed), 32'(0));

    // three frames back to back
    wr_bins(3 * N, 100, 0);
    drain();
    chk("contig_run", 32'(last_run), 32'(3 * N));
    chk("b2b_frames", 32'(frames_out), 32'(4));

    // 50% upstream duty
    wr_bins(4 * N, 50, 0);
    drain();
    chk("rand_frames", 32'(frames_out), 32'(8));

    // reset in the middle of a stream and of a partial write
    wr_bins(N + 100, 100, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_streaming", 32'(out_valid), 32'(1));
    rst = 1'b0;
    flush_model();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_frames", 32'(frames_out), 32'(0));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'(1));
    wr_bins(N, 100, 1);
    drain();
    chk("post_rst_frames", 32'(frames_out), 32'(1));

    // FRAME_GAP = 3 instance, two banks filled back to back
    begin
      int b = 0;
      int k = 0;
      while (b < 2 * N && k < 8 * N) begin
        @(negedge clk);
        k++;
        g_wr_valid  = 1'b1;
        g_wr_lambda = 14'(b % N);
        if (g_wr_ready) b++;
      end
      @(negedge clk);
      g_wr_valid = 1'b0;
      k = 0;
      while (g_frames_out != 16'd2 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      chk("gap_frames", 32'(g_frames_out), 32'(2));
      chk("gap_checked", 32'(g_gap_checks), 32'(1));
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
